// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter for the register file's single write port.
// Requester 0 is writeback (WB), requester 1 is multdiv (MD); one registered output stage.
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ready,
    input  logic                  md_valid,
    input  logic [ADDR_WIDTH-1:0] md_addr,
    input  logic [DATA_WIDTH-1:0] md_data,
    output logic                  md_ready,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  last_grant,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  wb_gnt_s;
    logic                  md_gnt_s;
    logic                  any_gnt_s;
    logic                  contend_s;
    logic [ADDR_WIDTH-1:0] gnt_addr_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;

    // Grant decision: freeze on hold/reset, otherwise round-robin between valid requesters.
    always_comb begin
        wb_gnt_s  = 1'b0;
        md_gnt_s  = 1'b0;
        contend_s = 1'b0;
        if (reset || hold) begin
            wb_gnt_s = 1'b0;
            md_gnt_s = 1'b0;
        end else begin
            case ({wb_valid, md_valid})
                2'b11: begin
                    // Pointer names the last winner, so the other side wins now.
                    contend_s = 1'b1;
                    if (last_grant == 1'b1) begin
                        wb_gnt_s = 1'b1;
                    end else begin
                        md_gnt_s = 1'b1;
                    end
                end
                2'b10:   wb_gnt_s = 1'b1;
                2'b01:   md_gnt_s = 1'b1;
                default: begin
                    wb_gnt_s = 1'b0;
                    md_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Steer the winning requester's address and data toward the output stage.
    always_comb begin
        gnt_addr_s = wb_addr;
        gnt_data_s = wb_data;
        if (md_gnt_s) begin
            gnt_addr_s = md_addr;
            gnt_data_s = md_data;
        end else begin
            gnt_addr_s = wb_addr;
            gnt_data_s = wb_data;
        end
    end

    assign wb_ready  = wb_gnt_s;
    assign md_ready  = md_gnt_s;
    assign any_gnt_s = wb_gnt_s | md_gnt_s;

    // Output stage, round-robin pointer and saturating contention counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= ADDR_ZERO;
            rf_wdata   <= DATA_ZERO;
            last_grant <= 1'b1;
            stall_cnt  <= CNT_ZERO;
        end else begin
            // r0 writes are acknowledged upstream but never reach the register file.
            rf_we <= any_gnt_s && (gnt_addr_s != ADDR_ZERO);
            if (any_gnt_s) begin
                rf_waddr   <= gnt_addr_s;
                rf_wdata   <= gnt_data_s;
                last_grant <= md_gnt_s;
            end else begin
                rf_waddr   <= rf_waddr;
                rf_wdata   <= rf_wdata;
                last_grant <= last_grant;
            end
            if (contend_s && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
        end
    end

endmodule
